// File: rtl/ccff_drv_pkg.sv
// Shared types, constants and the serial CRC-16-CCITT step for the chain driver.
package ccff_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT register with synchronous clear and step enable.
module ccff_crc16
    import ccff_drv_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;

    // Clear has priority over stepping so a new run always starts from the seed.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            crc_reg <= CRC_INIT;
        end else if (clr) begin
            crc_reg <= CRC_INIT;
        end else if (en) begin
            crc_reg <= crc16_step(crc_reg, din);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/ccff_chain_driver.sv
// Writer end of a serial configuration chain: serializes a word stream MSB-first
// onto ccff_head, then optionally rotates the chain once and CRC-checks readback.
module ccff_chain_driver
    import ccff_drv_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              chain_shift_en,
    output logic              config_enable,
    output logic              busy,
    output logic              done,
    output logic              crc_ok
);

    localparam int BIT_W = $clog2(CHAIN_LEN + 1);
    localparam int BUF_W = $clog2(WORD_W + 1);
    localparam logic [BIT_W-1:0] CHAIN_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BUF_W-1:0] WORD_FULL  = BUF_W'(WORD_W);

    state_t            state_reg, state_next;
    logic              verify_reg, verify_next;
    logic [WORD_W-1:0] buf_reg, buf_next;
    logic [BUF_W-1:0]  buf_cnt_reg, buf_cnt_next;
    logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              crc_ok_reg, crc_ok_next;

    logic              shifting;
    logic              room;
    logic              crc_clr;
    logic              load_crc_en;
    logic              rb_crc_en;
    logic [15:0]       load_crc;
    logic [15:0]       rb_crc;

    // CRC of the bits pushed into the chain during LOAD.
    ccff_crc16 u_load_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (crc_clr),
        .en       (load_crc_en),
        .din      (buf_reg[WORD_W-1]),
        .crc      (load_crc)
    );

    // CRC of the bits read back from the tail during VERIFY.
    ccff_crc16 u_rb_crc (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      (crc_clr),
        .en       (rb_crc_en),
        .din      (ccff_tail),
        .crc      (rb_crc)
    );

    // State register and datapath registers.
    always_ff @(posedge prog_clk) begin
        if (!pReset) begin
            state_reg   <= IDLE;
            verify_reg  <= 1'b0;
            buf_reg     <= '0;
            buf_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            crc_ok_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            verify_reg  <= verify_next;
            buf_reg     <= buf_next;
            buf_cnt_reg <= buf_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            crc_ok_reg  <= crc_ok_next;
        end
    end

    // Next-state, word acceptance, serialization and chain control.
    always_comb begin
        state_next     = state_reg;
        verify_next    = verify_reg;
        buf_next       = buf_reg;
        buf_cnt_next   = buf_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        crc_ok_next    = crc_ok_reg;
        shifting       = 1'b0;
        room           = 1'b0;
        s_ready        = 1'b0;
        ccff_head      = 1'b0;
        chain_shift_en = 1'b0;
        crc_clr        = 1'b0;
        load_crc_en    = 1'b0;
        rb_crc_en      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = LOAD;
                    verify_next  = verify_en;
                    crc_clr      = 1'b1;
                    crc_ok_next  = 1'b0;
                    bit_cnt_next = '0;
                    buf_cnt_next = '0;
                end
            end

            LOAD: begin
                shifting = (buf_cnt_reg != '0);
                // Never fetch a word whose bits would all land past the chain end.
                room     = (int'(bit_cnt_reg) + int'(buf_cnt_reg)) < CHAIN_LEN;
                // Refill on the last buffered bit so shifting stays gapless.
                s_ready  = room && ((buf_cnt_reg == '0) ||
                                    ((buf_cnt_reg == BUF_W'(1)) && shifting));
                if (shifting) begin
                    ccff_head      = buf_reg[WORD_W-1];
                    chain_shift_en = 1'b1;
                    load_crc_en    = 1'b1;
                    buf_next       = buf_reg << 1;
                    buf_cnt_next   = buf_cnt_reg - BUF_W'(1);
                    bit_cnt_next   = bit_cnt_reg + BIT_W'(1);
                end
                if (s_ready && s_valid) begin
                    buf_next     = s_data;
                    buf_cnt_next = WORD_FULL;
                end
                if (shifting && (bit_cnt_reg == CHAIN_LAST)) begin
                    // Chain full: drop leftover bits of a partial last word.
                    buf_cnt_next = '0;
                    bit_cnt_next = '0;
                    if (verify_reg) begin
                        state_next = VERIFY;
                    end else begin
                        state_next  = DONE;
                        crc_ok_next = 1'b1;
                    end
                end
            end

            VERIFY: begin
                ccff_head      = ccff_tail;
                chain_shift_en = 1'b1;
                rb_crc_en      = 1'b1;
                bit_cnt_next   = bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == CHAIN_LAST) begin
                    state_next   = DONE;
                    bit_cnt_next = '0;
                    // Fold in the final tail bit, which the register has not seen yet.
                    crc_ok_next  = (load_crc == crc16_step(rb_crc, ccff_tail));
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign config_enable = (state_reg == LOAD) || (state_reg == VERIFY);
    assign crc_ok        = crc_ok_reg;

endmodule

// File: tb/tb_ccff_chain_driver.sv
// Self-checking bench: behavioural chain model plus expected stream/timing
// derived from word list, per-word gaps and verify setting.
module tb_ccff_chain_driver;

    localparam int CL   = 37;
    localparam int W    = 8;
    localparam int NW   = 6;
    localparam int NACC = (CL + W - 1) / W;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic          verify_en = 1'b0;
    logic [W-1:0]  s_data   = '0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic          ccff_head;
    logic          ccff_tail;
    logic          chain_shift_en;
    logic          config_enable;
    logic          busy;
    logic          done;
    logic          crc_ok;

    logic [CL-1:0] chain_model;
    logic [CL-1:0] flip_mask;
    logic          flip_req = 1'b0;
    int            flip_idx = 0;

    logic [W-1:0]  words [NW];
    int            gaps  [NW];

    int checks = 0;
    int errors = 0;

    ccff_chain_driver #(
        .CHAIN_LEN (CL),
        .WORD_W    (W)
    ) dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start),
        .verify_en      (verify_en),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chain_shift_en (chain_shift_en),
        .config_enable  (config_enable),
        .busy           (busy),
        .done           (done),
        .crc_ok         (crc_ok)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: bit 0 is the head flop, bit CL-1 drives the tail.
    assign ccff_tail = chain_model[CL-1];
    assign flip_mask = flip_req ? (CL'(1) << flip_idx) : '0;

    always @(posedge prog_clk) begin
        if (chain_shift_en)
            chain_model <= {chain_model[CL-2:0], ccff_head} ^ flip_mask;
        else
            chain_model <= chain_model ^ flip_mask;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One load run; start at cycle 0. flip_at/rst_at/start2_at < 0 disables that event.
    task automatic run_case(input string name, input bit ver, input int flip_at,
                            input int rst_at, input int start2_at);
        int acc = 0, widx = 0, gap_left;
        int done_cyc = -1, done_cnt = 0;
        int first_ce = -1, last_ce = -1, ce_cnt = 0, stall_cnt = 0;
        bit shifted_once = 0;
        bit crc_at_done = 0;
        int sum_all = 0, sum_rest = 0, exp_done, limit;
        logic [CL-1:0] exp_chain;
        logic [W-1:0] wv;

        for (int i = 0; i < NACC; i++) begin
            sum_all += gaps[i];
            if (i > 0) sum_rest += gaps[i];
        end
        exp_done = CL + 2 + sum_all + (ver ? CL : 0);
        limit    = exp_done + 20;
        for (int k = 0; k < CL; k++) begin
            wv = words[k / W];
            exp_chain[CL-1-k] = wv[W-1-(k % W)];
        end
        gap_left = gaps[0];

        for (int cyc = 0; cyc <= limit; cyc++) begin
            pReset    = (cyc == rst_at) ? 1'b0 : 1'b1;
            start     = (cyc == 0) || (cyc == start2_at);
            verify_en = (cyc == 0) ? ver : ~ver;
            s_valid   = (widx < NW) && (gap_left == 0);
            s_data    = (widx < NW) ? words[widx] : W'($urandom);
            @(negedge prog_clk);
            if (rst_at >= 0 && cyc == rst_at + 1)
                chk({name, " reset_outputs"},
                    64'({s_ready, ccff_head, chain_shift_en, config_enable, busy, done, crc_ok}), 64'(0));
            if (s_valid && s_ready) begin
                acc++;
                widx++;
                gap_left = (widx < NW) ? gaps[widx] : 0;
            end else if (!s_valid && s_ready && gap_left > 0) begin
                gap_left--;
            end
            if (config_enable) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = cyc;
                last_ce = cyc;
                if (shifted_once && !chain_shift_en) stall_cnt++;
                if (chain_shift_en) shifted_once = 1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc    = cyc;
                    crc_at_done = crc_ok;
                end
            end
            if (cyc == flip_at) flip_req = 1'b1;
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                chk({name, " crc_ok_held"}, 64'(crc_ok), 64'(flip_at < 0));
                chk({name, " idle_after_done"}, 64'(busy), 64'(0));
                break;
            end
            @(posedge prog_clk);
            #1;
            flip_req = 1'b0;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        pReset  = 1'b1;
        flip_req = 1'b0;

        if (rst_at >= 0) begin
            chk({name, " no_done"}, 64'(done_cnt), 64'(0));
            chk({name, " busy_end"}, 64'(busy), 64'(0));
        end else begin
            chk({name, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
            chk({name, " done_pulses"}, 64'(done_cnt), 64'(1));
            chk({name, " words_accepted"}, 64'(acc), 64'(NACC));
            chk({name, " ce_first"}, 64'(first_ce), 64'(1));
            chk({name, " ce_last"}, 64'(last_ce), 64'(exp_done - 1));
            chk({name, " ce_cycles"}, 64'(ce_cnt), 64'(exp_done - 1));
            chk({name, " stall_cycles"}, 64'(stall_cnt), 64'(sum_rest));
            chk({name, " crc_ok"}, 64'(crc_at_done), 64'(flip_at < 0));
            if (flip_at < 0)
                chk({name, " chain"}, 64'(chain_model), 64'(exp_chain));
        end
        $display("case %s: verify=%0d done_cycle=%0d accepted=%0d stalls=%0d crc_ok=%0d",
                 name, ver, done_cyc, acc, stall_cnt, crc_at_done);
        @(posedge prog_clk);
        #1;
    endtask

    task automatic set_fixed_words();
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
        words[3] = 8'h00; words[4] = 8'hE8; words[5] = 8'h5A;
        for (int i = 0; i < NW; i++) gaps[i] = 0;
    endtask

    initial begin
        pReset = 1'b0;
        repeat (3) @(posedge prog_clk);
        #1;
        @(negedge prog_clk);
        chk("reset_state", 64'({s_ready, ccff_head, chain_shift_en, config_enable, busy, done, crc_ok}), 64'(0));
        @(posedge prog_clk);
        #1;
        pReset = 1'b1;
        @(posedge prog_clk);
        #1;

        set_fixed_words();
        run_case("load_noverify", 1'b0, -1, -1, -1);
        run_case("load_verify", 1'b1, -1, -1, -1);

        flip_idx = $urandom_range(CL-1, 20);
        run_case("verify_flip", 1'b1, CL + 2 + 10, -1, -1);

        set_fixed_words();
        gaps[2] = 4;
        run_case("stall4", 1'b0, -1, -1, -1);

        set_fixed_words();
        run_case("reset_mid_load", 1'b1, -1, 10, -1);
        run_case("after_reset", 1'b1, -1, -1, -1);
        run_case("start_in_load", 1'b0, -1, -1, 10);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NW; i++) begin
                words[i] = W'($urandom);
                gaps[i]  = int'($urandom_range(3, 0));
            end
            run_case($sformatf("random%0d", r), 1'($urandom_range(1, 0)), -1, -1,
                     (r % 2 == 1) ? 12 : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
